// File: rtl/fd_dx_stage_ctrl_pkg.sv
// Shared pipeline definitions for the front-end stage controller: NOP encoding,
// instruction field positions and the stage FSM state encoding.
package fd_dx_stage_ctrl_pkg;

   localparam logic [31:0] NOP = 32'd0;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 27;
   localparam int RD_MSB     = 26;
   localparam int RD_LSB     = 22;
   localparam int RS_MSB     = 21;
   localparam int RS_LSB     = 17;
   localparam int RT_MSB     = 16;
   localparam int RT_LSB     = 12;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_MDWAIT = 2'd2,
      ST_FLUSH  = 2'd3
   } stage_state_e;

   function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [31:0] ir);
      return ir[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic [RD_MSB-RD_LSB:0] rd_of(input logic [31:0] ir);
      return ir[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [RS_MSB-RS_LSB:0] rs_of(input logic [31:0] ir);
      return ir[RS_MSB:RS_LSB];
   endfunction

   function automatic logic [RT_MSB-RT_LSB:0] rt_of(input logic [31:0] ir);
      return ir[RT_MSB:RT_LSB];
   endfunction

endpackage

// File: rtl/fd_dx_stage_ctrl_pipe_latch.sv
// One pipeline latch (PC, instruction, valid). bubble loads a NOP and wins over en;
// with neither asserted the latch holds.
module fd_dx_stage_ctrl_pipe_latch
   import fd_dx_stage_ctrl_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   input  logic              bubble,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [31:0]       ir_i,
   input  logic              valid_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [31:0]       ir_o,
   output logic              valid_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [31:0]       ir_q;
   logic              valid_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clock) begin
      if (reset || bubble) begin
         pc_q    <= '0;
         ir_q    <= NOP;
         valid_q <= 1'b0;
      end else if (en) begin
         pc_q    <= pc_i;
         ir_q    <= ir_i;
         valid_q <= valid_i;
      end
   end

   assign pc_o    = pc_q;
   assign ir_o    = ir_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fd_dx_stage_ctrl.sv
// Front-end hold/bubble/flush controller owning the PC and the F/D and D/X latches.
// Define STALL_PERF_CNT_EN to build the saturating stall/flush performance counters.
module fd_dx_stage_ctrl
   import fd_dx_stage_ctrl_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int MAX_STALL = 64,
   parameter int CNT_W     = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       imem_q,
   input  logic              stall_req,
   input  logic              md_busy,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] fd_pc,
   output logic [ADDR_W-1:0] dx_pc,
   output logic [31:0]       fd_ir,
   output logic [31:0]       dx_ir,
   output logic              fd_valid,
   output logic              dx_valid,
   output logic [1:0]        state_out,
   output logic              stall_timeout,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   localparam int CONSEC_W = $clog2(MAX_STALL + 1);
   localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_STALL);

   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W-1:0]   pc_inc;
   stage_state_e        state_q;
   stage_state_e        act;
   logic [CONSEC_W-1:0] consec_q;
   logic [CONSEC_W-1:0] consec_d;
   logic                timeout_q;
   logic                eff_stall;

   // A stall request against a NOP in F/D has nothing to protect.
   assign eff_stall = stall_req & fd_valid;
   assign pc_inc    = pc_q + ADDR_W'(1);

   // The action taken this edge doubles as the next FSM state.
   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      act = ST_RUN;
      if (branch_taken)   act = ST_FLUSH;
      else if (md_busy)   act = ST_MDWAIT;
      else if (eff_stall) act = ST_BUBBLE;
   end

   always_comb begin
      consec_d = '0;
      if (act == ST_MDWAIT || act == ST_BUBBLE)
         consec_d = (consec_q == CONSEC_MAX) ? consec_q : consec_q + CONSEC_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q      <= '0;
         state_q   <= ST_RUN;
         consec_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q  <= act;
         consec_q <= consec_d;
         if (consec_d == CONSEC_MAX) timeout_q <= 1'b1;
         case (act)
            ST_FLUSH: pc_q <= branch_target;
            ST_RUN:   pc_q <= pc_inc;
            default:  pc_q <= pc_q;
         endcase
      end
   end

   fd_dx_stage_ctrl_pipe_latch #(.ADDR_W(ADDR_W)) u_fd_latch (
      .clock   (clock),
      .reset   (reset),
      .en      (act == ST_RUN),
      .bubble  (act == ST_FLUSH),
      .pc_i    (pc_inc),
      .ir_i    (imem_q),
      .valid_i (1'b1),
      .pc_o    (fd_pc),
      .ir_o    (fd_ir),
      .valid_o (fd_valid)
   );

   fd_dx_stage_ctrl_pipe_latch #(.ADDR_W(ADDR_W)) u_dx_latch (
      .clock   (clock),
      .reset   (reset),
      .en      (act == ST_RUN),
      .bubble  (act == ST_FLUSH || act == ST_BUBBLE),
      .pc_i    (fd_pc),
      .ir_i    (fd_ir),
      .valid_i (fd_valid),
      .pc_o    (dx_pc),
      .ir_o    (dx_ir),
      .valid_o (dx_valid)
   );

   assign pc_out        = pc_q;
   assign state_out     = state_q;
   assign stall_timeout = timeout_q;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if ((act == ST_MDWAIT || act == ST_BUBBLE) && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (act == ST_FLUSH && flush_cnt_q != '1)
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
